// File: rtl/fpu_align_pipe.sv
// Two-stage operand comparator and mantissa aligner for the FPU add/sub path.
// Stage 1 orders the operands by magnitude; stage 2 right-shifts the smaller mantissa with guard/sticky bits.
module fpu_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 24,
  parameter int GUARD = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [EXP_W-1:0]         a_exp,
  input  logic [EXP_W-1:0]         b_exp,
  input  logic [MAN_W-1:0]         a_man,
  input  logic [MAN_W-1:0]         b_man,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W-1:0]         out_exp,
  output logic [MAN_W+GUARD-1:0]   out_man_big,
  output logic [MAN_W+GUARD-1:0]   out_man_small,
  output logic [EXP_W-1:0]         out_exp_diff,
  output logic                     out_swap,
  output logic                     out_eq
);

  localparam int AW = MAN_W + GUARD;

  // Valid/ready: a beat moves across a boundary on a rising edge where valid and
  // ready are both high; valid holds with stable data until that edge, and ready
  // depends only on downstream ready and the stage valid flags.
  logic             r_s1_valid;
  logic [EXP_W-1:0] r_s1_exp;
  logic [MAN_W-1:0] r_s1_big_man;
  logic [MAN_W-1:0] r_s1_small_man;
  logic [EXP_W-1:0] r_s1_diff;
  logic             r_s1_swap;
  logic             r_s1_eq;

  logic             r_out_valid;
  logic [EXP_W-1:0] r_out_exp;
  logic [AW-1:0]    r_out_man_big;
  logic [AW-1:0]    r_out_man_small;
  logic [EXP_W-1:0] r_out_diff;
  logic             r_out_swap;
  logic             r_out_eq;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_swap;
  logic             w_eq;
  logic [EXP_W-1:0] w_big_exp;
  logic [EXP_W-1:0] w_small_exp;
  logic [MAN_W-1:0] w_big_man;
  logic [MAN_W-1:0] w_small_man;
  logic [AW-1:0]    w_ext;
  logic             w_over;
  logic [AW-1:0]    w_shifted;
  logic             w_sticky;
  logic [AW-1:0]    w_man_small;

  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;

  assign w_swap      = (b_exp > a_exp) || ((b_exp == a_exp) && (b_man > a_man));
  assign w_eq        = (a_exp == b_exp) && (a_man == b_man);
  assign w_big_exp   = w_swap ? b_exp : a_exp;
  assign w_small_exp = w_swap ? a_exp : b_exp;
  assign w_big_man   = w_swap ? b_man : a_man;
  assign w_small_man = w_swap ? a_man : b_man;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid     <= 1'b0;
      r_s1_exp       <= '0;
      r_s1_big_man   <= '0;
      r_s1_small_man <= '0;
      r_s1_diff      <= '0;
      r_s1_swap      <= 1'b0;
      r_s1_eq        <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_exp       <= w_big_exp;
        r_s1_big_man   <= w_big_man;
        r_s1_small_man <= w_small_man;
        r_s1_diff      <= w_big_exp - w_small_exp;
        r_s1_swap      <= w_swap;
        r_s1_eq        <= w_eq;
      end
    end
  end

  // Shifts of AW or more push every bit out, so only the sticky survives.
  assign w_ext       = {r_s1_small_man, {GUARD{1'b0}}};
  assign w_over      = 32'(r_s1_diff) >= 32'(AW);
  assign w_shifted   = w_over ? '0 : (w_ext >> r_s1_diff);
  assign w_sticky    = w_over ? (|r_s1_small_man)
                              : (|(w_ext & ~({AW{1'b1}} << r_s1_diff)));
  assign w_man_small = {w_shifted[AW-1:1], w_shifted[0] | w_sticky};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid     <= 1'b0;
      r_out_exp       <= '0;
      r_out_man_big   <= '0;
      r_out_man_small <= '0;
      r_out_diff      <= '0;
      r_out_swap      <= 1'b0;
      r_out_eq        <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_exp       <= r_s1_exp;
        r_out_man_big   <= {r_s1_big_man, {GUARD{1'b0}}};
        r_out_man_small <= w_man_small;
        r_out_diff      <= r_s1_diff;
        r_out_swap      <= r_s1_swap;
        r_out_eq        <= r_s1_eq;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_exp       = r_out_exp;
  assign out_man_big   = r_out_man_big;
  assign out_man_small = r_out_man_small;
  assign out_exp_diff  = r_out_diff;
  assign out_swap      = r_out_swap;
  assign out_eq        = r_out_eq;

endmodule
